// File: rtl/schoolbook_ctrl_pkg.sv
// Shared defaults and state encoding for the schoolbook multiplier controller.
// ST_WAIT is only reachable when SCHOOLBOOK_CTRL_CAPTURE_EN is defined.
package schoolbook_ctrl_pkg;

  localparam int N_DEF = 224;
  localparam int W_DEF = 32;

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WAIT  = 3'd4
  } state_e;

endpackage

// File: rtl/schoolbook_out_ser.sv
// Product serializer: walks a 2N-bit source word by word, LS word first,
// over a valid/ready bus and flags the final word.
module schoolbook_out_ser
  import schoolbook_ctrl_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           valid_i,
  input  logic [2*N-1:0] src_i,
  input  logic           out_ready_i,
  output logic           out_valid_o,
  output logic [W-1:0]   out_data_o,
  output logic           out_last_o,
  output logic           done_o
);

  localparam int NWORDS = (2 * N) / W;
  localparam int IDX_W  = $clog2(NWORDS);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             fire;

  assign out_valid_o = valid_i;
  assign out_last_o  = valid_i && (idx_q == IDX_W'(NWORDS - 1));
  assign out_data_o  = src_i[int'(idx_q)*W +: W];
  assign fire        = valid_i && out_ready_i;
  assign done_o      = fire && out_last_o;

  always_comb begin
    idx_d = idx_q;
    if (fire) idx_d = out_last_o ? '0 : idx_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) idx_q <= '0;
    else         idx_q <= idx_d;
  end

endmodule

// File: rtl/schoolbook_ctrl.sv
// Operand loader, step sequencer and product drain for the bit-serial multiplier.
// Define SCHOOLBOOK_CTRL_CAPTURE_EN to buffer the product so loading overlaps the drain.
//
//  state | meaning
//  LOAD  | accept 2*NW operand words, multiplier held in reset
//  CLEAR | one cycle of multiplier reset with operands stable
//  RUN   | N multiplier steps
//  DRAIN | stream mul_c out (sequential build only)
//  WAIT  | product final, waiting for the result buffer (capture build only)
module schoolbook_ctrl
  import schoolbook_ctrl_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  output logic           mul_rst,
  output logic [N-1:0]   mul_a,
  output logic [N-1:0]   mul_b,
  input  logic [2*N-1:0] mul_c,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           out_last
);

  localparam int NW    = N / W;
  localparam int IDX_W = $clog2(2 * NW);
  localparam int CNT_W = $clog2(N + 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] in_idx_q, in_idx_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [N-1:0]     a_q, a_d, b_q, b_d;
  logic             in_fire, ser_valid, ser_done;
  logic [2*N-1:0]   ser_src;
  int               widx;

  assign in_ready = rst && (state_q == ST_LOAD);
  assign in_fire  = in_valid && in_ready;
  assign mul_rst  = rst && (state_q == ST_RUN || state_q == ST_DRAIN || state_q == ST_WAIT);
  assign mul_a    = a_q;
  assign mul_b    = b_q;

`ifdef SCHOOLBOOK_CTRL_CAPTURE_EN
  logic           capture, rbuf_full_q, rbuf_full_d;
  logic [2*N-1:0] rbuf_q;

  // A capture coinciding with the freeing out_last handshake keeps the buffer full.
  assign rbuf_full_d = capture ? 1'b1 : (ser_done ? 1'b0 : rbuf_full_q);
  assign ser_valid   = rst && rbuf_full_q;
  assign ser_src     = rbuf_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rbuf_full_q <= 1'b0;
      rbuf_q      <= '0;
    end else begin
      rbuf_full_q <= rbuf_full_d;
      if (capture) rbuf_q <= mul_c;
    end
  end
`else
  assign ser_valid = rst && (state_q == ST_DRAIN);
  assign ser_src   = mul_c;
`endif

  always_comb begin
    state_d   = state_q;
    in_idx_d  = in_idx_q;
    run_cnt_d = run_cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    widx      = int'(in_idx_q);
`ifdef SCHOOLBOOK_CTRL_CAPTURE_EN
    capture   = 1'b0;
`endif
    case (state_q)
      ST_LOAD: begin
        if (in_fire) begin
          if (in_idx_q < IDX_W'(NW)) a_d[widx*W +: W] = in_data;
          else                       b_d[(widx-NW)*W +: W] = in_data;
          if (in_idx_q == IDX_W'(2*NW - 1)) begin
            in_idx_d = '0;
            state_d  = ST_CLEAR;
          end else begin
            in_idx_d = in_idx_q + 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        run_cnt_d = '0;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        if (run_cnt_q == CNT_W'(N - 1)) begin
          run_cnt_d = '0;
`ifdef SCHOOLBOOK_CTRL_CAPTURE_EN
          // The Nth step lands on this edge, so mul_c is only final one cycle later.
          state_d   = ST_WAIT;
`else
          state_d   = ST_DRAIN;
`endif
        end else begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (ser_done) state_d = ST_LOAD;
      end
`ifdef SCHOOLBOOK_CTRL_CAPTURE_EN
      ST_WAIT: begin
        if (!rbuf_full_q || ser_done) begin
          capture = 1'b1;
          state_d = ST_LOAD;
        end
      end
`endif
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_LOAD;
      in_idx_q  <= '0;
      run_cnt_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      state_q   <= state_d;
      in_idx_q  <= in_idx_d;
      run_cnt_q <= run_cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
    end
  end

  schoolbook_out_ser #(.N(N), .W(W)) u_out_ser (
    .clk_i       (clk),
    .rst_ni      (rst),
    .valid_i     (ser_valid),
    .src_i       (ser_src),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .done_o      (ser_done)
  );

endmodule

// File: tb/tb_schoolbook_ctrl.sv
// Randomized bench for schoolbook_ctrl: a stand-in multiplier plus a word scoreboard
// built from plain a*b products of the operands the bench sends.
module tb_schoolbook_ctrl;

  localparam int N  = 224;
  localparam int W  = 32;
  localparam int NW = N / W;
`ifdef SCHOOLBOOK_CTRL_CAPTURE_EN
  localparam int LAT = N + 2;
`else
  localparam int LAT = N + 1;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_data = '0;
  logic           mul_rst;
  logic [N-1:0]   mul_a, mul_b;
  logic [2*N-1:0] mul_c;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_data;
  logic           out_last;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int t_last = 0;
  int rdy_mode = 0;
  int mstep = 0;
  logic [2*N-1:0] mc = '0;

  logic [W-1:0] exp_q[$];
  bit           last_q[$];

  schoolbook_ctrl #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mul_rst(mul_rst), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in multiplier: the product appears only after exactly N enabled steps.
  always @(posedge clk) begin
    if (!mul_rst) begin
      mstep <= 0;
      mc    <= '0;
    end else if (mstep < N) begin
      mstep <= mstep + 1;
      mc    <= (mstep == N - 1) ? ({{N{1'b0}}, mul_a} * {{N{1'b0}}, mul_b}) : ~mc;
    end
  end
  assign mul_c = mc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] rand_op();
    logic [N-1:0] r;
    for (int i = 0; i < NW; i++) r[i*W +: W] = $urandom;
    return r;
  endfunction

  // Output side: drive out_ready for the coming edge, then score any handshake it implies.
  initial begin
    int rp = 0;
    bit prev_valid = 0;
    bit hold_pending = 0;
    logic [W-1:0] held = '0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        1: begin out_ready = (rp == 0); rp = (rp + 1) % 3; end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      if (rst && out_valid) begin
        if (!prev_valid) chk("steps_at_drain", 64'(mstep), 64'(N));
        if (hold_pending) chk("hold_stable", 64'(out_data), 64'(held));
        if (out_ready) begin
          chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
            chk("out_last", 64'(out_last), 64'(last_q.pop_front()));
          end
          hold_pending = 0;
        end else begin
          hold_pending = 1;
          held = out_data;
        end
      end else begin
        hold_pending = 0;
      end
      prev_valid = rst && out_valid;
    end
  end

  task automatic send_word(input logic [W-1:0] w, input bit gaps);
    int waits = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && waits < 3000) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 3000) chk("in_ready_timeout", 64'(waits), 64'd0);
    t_last = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_op(input logic [N-1:0] a, input logic [N-1:0] b, input bit gaps);
    logic [2*N-1:0] p;
    p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    for (int i = 0; i < 2*NW; i++) begin
      exp_q.push_back(p[i*W +: W]);
      last_q.push_back(i == 2*NW - 1);
    end
    for (int i = 0; i < 2*NW; i++)
      send_word((i < NW) ? a[i*W +: W] : b[(i-NW)*W +: W], gaps);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [N-1:0] ones;
    int n;
    ones = '1;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_mul_rst", 64'(mul_rst), 64'd0);
    chk("rst_mul_a_zero", 64'(mul_a == '0), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("load_in_ready", 64'(in_ready), 64'd1);
    chk("load_mul_rst", 64'(mul_rst), 64'd0);

    // a=b=1, continuous input, latency and CLEAR/RUN mul_rst timing; junk in_valid during RUN.
    rdy_mode = 0;
    send_op(224'd1, 224'd1, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'hBAD0_BAD0;
    chk("clear_mul_rst", 64'(mul_rst), 64'd0);
    chk("clear_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("run_mul_rst", 64'(mul_rst), 64'd1);
    n = 0;
    while (!out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk("latency", 64'(cyc - t_last), 64'(LAT));
    wait_drain();

    // All-ones operands under 1,0,0 backpressure and input gaps.
    rdy_mode = 1;
    send_op(ones, ones, 1'b1);
    wait_drain();

    // Random operands, random gaps and ready; issued back to back.
    rdy_mode = 2;
    for (int k = 0; k < 4; k++) send_op(rand_op(), rand_op(), 1'b1);
    send_op('0, rand_op(), 1'b1);
    wait_drain();

    // Reset in the middle of RUN aborts the operation without output.
    rdy_mode = 0;
    send_op(rand_op(), rand_op(), 1'b0);
    n = 0;
    while (mstep < 100 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_run", 64'(mstep), 64'd100);
    rst = 1'b0;
    exp_q.delete();
    last_q.delete();
    @(negedge clk);
    chk("abort_in_ready", 64'(in_ready), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_mul_rst", 64'(mul_rst), 64'd0);
    chk("abort_mul_b_zero", 64'(mul_b == '0), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    send_op(224'd3, 224'd5, 1'b1);
    wait_drain();

    // Slow drain while the next operands are offered immediately.
    rdy_mode = 1;
    for (int k = 0; k < 3; k++) send_op(rand_op(), rand_op(), 1'b0);
    wait_drain();

    rdy_mode = 0;
    repeat (40) @(negedge clk);
    chk("idle_no_valid", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
